// File: rtl/gf163_reduce_seq.sv
// rtl/gf163_reduce_seq.sv - sequential GF(2^163) reducer, folds FOLD high bits per clock
module gf163_reduce_seq #(
    parameter int FOLD = 54
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [324:0] in_prod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] out_c,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, FOLDING, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [324:0]   w;
    logic [8:0]     hi;
    logic [8:0]     lo;
    logic [324:0]   mask;
    logic [161:0]   chunk;
    logic [324:0]   fold;
    logic [324:0]   w_folded;
    logic           last_fold;

    // Chunk W[hi:lo] realigned to bit 0 is exactly C<<s, so one x^163 substitution
    // (x^0 + x^3 + x^6 + x^7) applied to the realigned chunk performs the fold.
    always_comb begin
        lo       = (hi >= 9'(163 + FOLD - 1)) ? hi - 9'(FOLD - 1) : 9'd163;
        mask     = ({325{1'b1}} << lo) & ({325{1'b1}} >> (9'd324 - hi));
        chunk    = w[324:163] & mask[324:163];
        fold     = {163'b0, chunk} ^ ({163'b0, chunk} << 3)
                 ^ ({163'b0, chunk} << 6) ^ ({163'b0, chunk} << 7);
        w_folded = (w & ~mask) ^ fold;
        last_fold = (lo == 9'd163);
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE) && !rst;
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = FOLDING;
            FOLDING: if (last_fold)            state_next = DONE;
            DONE:    if (out_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w     <= '0;
            hi    <= 9'd324;
            out_c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w  <= in_prod;
                        hi <= 9'd324;
                    end
                end
                FOLDING: begin
                    w  <= w_folded;
                    hi <= lo - 9'd1;
                    if (last_fold) out_c <= w_folded[162:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf163_reduce_seq.sv
// tb/tb_gf163_reduce_seq.sv - scoreboard bench for gf163_reduce_seq across several FOLD widths
module tb_gf163_reduce_seq;

    typedef struct {
        logic [162:0] exp;
        int           acc;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_chk;
    int   n_pass;
    logic done [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_chk  = 0;
        n_pass = 0;
    end

    task automatic chk(input string nm, input logic [162:0] act, input logic [162:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Bit-serial long division by f(x): clear each set high bit x^i, add x^(i-163)*(1+x^3+x^6+x^7).
    function automatic logic [162:0] ref_reduce(input logic [324:0] p);
        logic [324:0] r;
        r = p;
        for (int i = 324; i >= 163; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i - 163] = ~r[i - 163];
                r[i - 160] = ~r[i - 160];
                r[i - 157] = ~r[i - 157];
                r[i - 156] = ~r[i - 156];
            end
        end
        return r[162:0];
    endfunction

    function automatic logic [324:0] rand_prod();
        logic [324:0] p;
        int           m;
        p = '0;
        m = $urandom_range(0, 7);
        if (m == 0) begin
            repeat ($urandom_range(1, 4)) p[$urandom_range(0, 324)] = 1'b1;
        end else begin
            for (int k = 0; k < 11; k++) p = {p[292:0], 32'($urandom)};
            if (m == 1) p[324:163] = '0;
            if (m == 2) p[162:0] = '0;
        end
        return p;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int FV = (g == 0) ? 54 : (g == 1) ? 1 : (g == 2) ? 7 : 155;
        localparam int NF = (162 + FV - 1) / FV;

        logic         rst;
        logic         in_valid;
        logic         in_ready;
        logic [324:0] in_prod;
        logic         out_valid;
        logic         out_ready;
        logic [162:0] out_c;
        logic         busy;
        logic         rand_ready;
        logic         seen;
        exp_t         q [$];

        gf163_reduce_seq #(.FOLD(FV)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_prod   (in_prod),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_c     (out_c),
            .busy      (busy)
        );

        always @(posedge clk) begin
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                q.delete();
                seen = 1'b0;
            end else begin
                chk($sformatf("f%0d_busy", FV), busy, q.size() != 0);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk($sformatf("f%0d_stale_valid", FV), out_valid, 1'b0);
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            chk($sformatf("f%0d_latency", FV), 163'(cyc - q[0].acc), 163'(NF));
                        end
                        if (out_ready) begin
                            chk($sformatf("f%0d_out_c", FV), out_c, q[0].exp);
                            void'(q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    e.exp = ref_reduce(in_prod);
                    e.acc = cyc + 1;
                    q.push_back(e);
                end
            end
        end

        task automatic send(input logic [324:0] p);
            int t;
            t = 0;
            @(posedge clk);
            #1;
            in_prod  = p;
            in_valid = 1'b1;
            while (t < 3000) begin
                @(negedge clk);
                if (in_ready) break;
                t++;
            end
            if (t >= 3000) chk($sformatf("f%0d_accept_timeout", FV), 163'(t), 163'(0));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic wait_ov();
            int t;
            t = 0;
            while (t < 3000) begin
                @(negedge clk);
                if (out_valid) break;
                t++;
            end
            if (t >= 3000) chk($sformatf("f%0d_valid_timeout", FV), 163'(t), 163'(0));
        endtask

        task automatic run_random(input int n);
            int t;
            rand_ready = 1'b1;
            for (int i = 0; i < n; i++) send(rand_prod());
            t = 0;
            while (q.size() != 0 && t < 5000) begin
                @(posedge clk);
                t++;
            end
            if (q.size() != 0) chk($sformatf("f%0d_drain_timeout", FV), 163'(q.size()), 163'(0));
            rand_ready = 1'b0;
        endtask

        if (g == 0) begin : directed
            initial begin
                logic [324:0] p;
                logic [167:0] pat;
                logic [162:0] held;
                done[g]    = 1'b0;
                rand_ready = 1'b0;
                seen       = 1'b0;
                rst        = 1'b1;
                in_valid   = 1'b0;
                in_prod    = '0;
                out_ready  = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("rst_in_ready", in_ready, 1'b0);
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_out_c", out_c, '0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("idle_in_ready", in_ready, 1'b1);

                p = '0;
                p[163] = 1'b1;
                send(p);
                wait_ov();
                chk("x163", out_c, 163'h0C9);

                p = '0;
                p[324] = 1'b1;
                send(p);
                wait_ov();
                chk("x324", out_c, (163'(1) << 161) | 163'h1422);

                pat = {21{8'hA5}};
                p = {162'b0, pat[162:0]};
                send(p);
                wait_ov();
                chk("low_only", out_c, pat[162:0]);

                send(rand_prod());
                out_ready = 1'b0;
                wait_ov();
                held = out_c;
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                in_prod  = rand_prod();
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_out_valid", out_valid, 1'b1);
                    chk("bp_out_c", out_c, held);
                    chk("bp_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("bp_release_valid", out_valid, 1'b0);
                chk("bp_release_ready", in_ready, 1'b1);
                send(rand_prod());
                wait_ov();

                send(rand_prod());
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(negedge clk);
                chk("midrst_in_ready", in_ready, 1'b0);
                @(posedge clk);
                @(negedge clk);
                chk("midrst_out_valid", out_valid, 1'b0);
                chk("midrst_out_c", out_c, '0);
                chk("midrst_busy", busy, 1'b0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("midrst_in_ready_after", in_ready, 1'b1);
                repeat (8) @(posedge clk);
                send(rand_prod());
                wait_ov();

                run_random(1000);
                done[g] = 1'b1;
            end
        end else begin : sweep
            initial begin
                done[g]    = 1'b0;
                rand_ready = 1'b0;
                seen       = 1'b0;
                rst        = 1'b1;
                in_valid   = 1'b0;
                in_prod    = '0;
                out_ready  = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                run_random((FV == 1) ? 120 : 1000);
                done[g] = 1'b1;
            end
        end
    end

    initial begin
        int t;
        t = 0;
        #1;
        while (!(done[0] === 1'b1 && done[1] === 1'b1 && done[2] === 1'b1 && done[3] === 1'b1)
               && t < 95000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 95000) chk("global_timeout", 163'(t), 163'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
